// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a word-count header plus little-endian words and writes them to instruction memory.
// Optional LOADER_CHECKSUM_EN expects a trailing XOR checksum byte before releasing the core.
module uart_imem_loader #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int AW1   = ADDR_W + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {L_WAIT_HDR, L_RECV, L_CHECK, L_DONE, L_ERROR} ld_state_t;
`else
    typedef enum logic [2:0] {L_WAIT_HDR, L_RECV, L_DONE, L_ERROR} ld_state_t;
`endif

    logic             rx_meta, rx_s;
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             half_tick, full_tick;
    logic             byte_valid, frame_err;

    ld_state_t         state, state_next;
    logic [7:0]        n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic              last_word, hdr_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign half_tick = (clk_cnt == CNT_W'(HALF - 1));
    assign full_tick = (clk_cnt == CNT_W'(CPB - 1));

    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            // mid start bit: a high line here means the falling edge was a glitch
            RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (full_tick) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = !rx_s;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == RX_IDLE || rx_state != rx_next || full_tick)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;
            if (rx_state == RX_IDLE)
                bit_idx <= '0;
            if (rx_state == RX_DATA && full_tick) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    assign last_word = (({1'b0, word_idx} + AW1'(1)) == AW1'(n_words));
    assign hdr_bad   = (shreg == 8'd0) || ({24'd0, shreg} > 32'(DEPTH));

    always_comb begin
        state_next = state;
        case (state)
            L_WAIT_HDR: begin
                if (frame_err)       state_next = L_ERROR;
                else if (byte_valid) state_next = hdr_bad ? L_ERROR : L_RECV;
            end
            L_RECV: begin
                if (frame_err) state_next = L_ERROR;
`ifdef LOADER_CHECKSUM_EN
                else if (imem_we && last_word) state_next = L_CHECK;
`else
                else if (imem_we && last_word) state_next = L_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            L_CHECK: begin
                if (frame_err)       state_next = L_ERROR;
                else if (byte_valid) state_next = (shreg == csum) ? L_DONE : L_ERROR;
            end
`endif
            L_DONE:  state_next = L_DONE;
            L_ERROR: state_next = L_ERROR;
            default: state_next = L_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= L_WAIT_HDR;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (state == L_WAIT_HDR && byte_valid)
                n_words <= shreg;
            if (state == L_RECV && byte_valid) begin
                byte_cnt <= byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ shreg;
`endif
                case (byte_cnt)
                    2'd0: word_buf[7:0]   <= shreg;
                    2'd1: word_buf[15:8]  <= shreg;
                    2'd2: word_buf[23:16] <= shreg;
                    default: begin
                        imem_we    <= 1'b1;
                        imem_wdata <= {shreg, word_buf};
                        imem_addr  <= word_idx;
                    end
                endcase
            end
            if (imem_we)
                word_idx <= word_idx + 1'b1;
        end
    end

    assign cpu_rst = (state != L_DONE);
    assign done    = (state == L_DONE);
    assign err     = (state == L_ERROR);
endmodule
